// File: rtl/demuxnx2_pkg.sv
// Shared constants and occupancy encoding for the 1-to-2 stream demultiplexer.
package demuxnx2_pkg;

  localparam int DEPTH = 2;
  localparam int OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/demuxnx2_fifo2.sv
// Two-entry FIFO for one output channel, with a wrapping count of words popped.
module demuxnx2_fifo2
  import demuxnx2_pkg::*;
#(
  parameter int M     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [M-1:0]     push_data,
  input  logic             pop_ready,
  output logic             valid,
  output logic             full,
  output logic [M-1:0]     head_data,
  output logic [CNT_W-1:0] cnt
);

  occ_e             state_q;
  occ_e             state_d;
  logic [M-1:0]     mem [DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CNT_W-1:0] cnt_q;

  // Pushes are dropped when full, so the occupancy can never overflow.
  assign do_push = push && !full;
  assign do_pop  = valid && pop_ready;

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Occupancy moves up on a lone push and down on a lone pop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OCC_EMPTY: if (do_push) state_d = OCC_ONE;
      OCC_ONE: begin
        if (do_push && !do_pop) state_d = OCC_FULL;
        else if (do_pop && !do_push) state_d = OCC_EMPTY;
      end
      OCC_FULL:  if (do_pop) state_d = OCC_ONE;
      default:   state_d = OCC_EMPTY;
    endcase
  end

  // Status outputs come straight from the registered occupancy.
  always_comb begin
    valid = (state_q != OCC_EMPTY);
    full  = (state_q == OCC_FULL);
  end

  // Storage and pointers; reset clears entries so the head word reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Delivered-word counter, wraps silently at its maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (do_pop) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign head_data = mem[rd_ptr];
  assign cnt       = cnt_q;

endmodule

// File: rtl/demuxnx2_stream.sv
// Registered 1-to-2 demultiplexer: each tagged input word goes to the FIFO of its channel.
module demuxnx2_stream
  import demuxnx2_pkg::*;
#(
  parameter int M     = 16,
  parameter int CNT_W = 8
) (
  input  logic             demuxnx2_port_clk,
  input  logic             demuxnx2_port_rst_n,
  input  logic             demuxnx2_port_in_valid,
  output logic             demuxnx2_port_in_ready,
  input  logic             demuxnx2_port_in_sel,
  input  logic [M-1:0]     demuxnx2_port_in_data,
  output logic             demuxnx2_port_out0_valid,
  input  logic             demuxnx2_port_out0_ready,
  output logic [M-1:0]     demuxnx2_port_out0_data,
  output logic             demuxnx2_port_out1_valid,
  input  logic             demuxnx2_port_out1_ready,
  output logic [M-1:0]     demuxnx2_port_out1_data,
  output logic [CNT_W-1:0] demuxnx2_port_cnt0,
  output logic [CNT_W-1:0] demuxnx2_port_cnt1
);

  logic full0;
  logic full1;
  logic push0;
  logic push1;

  // Ready depends only on the selected channel's registered fullness, never on out ready.
  always_comb begin
    demuxnx2_port_in_ready = demuxnx2_port_in_sel ? !full1 : !full0;
    push0 = demuxnx2_port_in_valid && !demuxnx2_port_in_sel && !full0;
    push1 = demuxnx2_port_in_valid &&  demuxnx2_port_in_sel && !full1;
  end

  demuxnx2_fifo2 #(.M(M), .CNT_W(CNT_W)) u_ch0 (
    .clk       (demuxnx2_port_clk),
    .rst_n     (demuxnx2_port_rst_n),
    .push      (push0),
    .push_data (demuxnx2_port_in_data),
    .pop_ready (demuxnx2_port_out0_ready),
    .valid     (demuxnx2_port_out0_valid),
    .full      (full0),
    .head_data (demuxnx2_port_out0_data),
    .cnt       (demuxnx2_port_cnt0)
  );

  demuxnx2_fifo2 #(.M(M), .CNT_W(CNT_W)) u_ch1 (
    .clk       (demuxnx2_port_clk),
    .rst_n     (demuxnx2_port_rst_n),
    .push      (push1),
    .push_data (demuxnx2_port_in_data),
    .pop_ready (demuxnx2_port_out1_ready),
    .valid     (demuxnx2_port_out1_valid),
    .full      (full1),
    .head_data (demuxnx2_port_out1_data),
    .cnt       (demuxnx2_port_cnt1)
  );

endmodule
